onehot_line_encoder: RTL and testbench

- Inverse of the team's 3-bit counter to 7-line decoder. Samples a 7-line indicator bus, for example looped back from a chaser board or driven by switches on ui_in[6:0].
- Synchronises the bus, debounces it and classifies it as idle, single-hot or multi-hot.
- A valid single-hot pattern is encoded back to the 3-bit count that would have lit that line. The result is presented with a one-cycle strobe, a sticky error flag and an event counter.
- Sits between the input pins and the counter/display logic in the same tile.

---
 rtl/onehot_line_encoder.sv | 191 +++++++++++++++++++
 tb/tb_onehot_line_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_line_encoder.sv
// onehot_line_encoder
//
// Turns a 7-line indicator bus back into the 3-bit count that lights that
// line on the counter-to-7-line decoder. The raw lines are synchronised with a
// two-flop chain, debounced, and then classified as idle, single-hot or
// multi-hot.
//   - A debounced single-hot pattern is encoded. code_out is updated, valid is
//     strobed for one cycle and evt_cnt is incremented.
//   - A multi-hot pattern sets the sticky err flag instead.
//   - After a report the bus must be released (all zero) for DEBOUNCE cycles
//     before a new pattern is considered.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   ena       clock enable; when low all state holds and valid is forced low
//   line_in   raw indicator lines (asynchronous to clk)
//   err_clr   synchronous clear of the sticky error flag
//   code_out  last accepted count value
//   valid     one-cycle strobe when code_out updates
//   err       sticky multi-hot error
//   busy      high whenever the FSM is not in IDLE
//   evt_cnt   number of accepted codes, wraps modulo 2^CNT_W
//
// Optional build macro ONEHOT_ENC_LINE6_ALT_EN:
//   Line 6 is lit by two counter states (1 and 5). With the macro defined, a
//   toggle flop alternates the line-6 decode 1, 5, 1, ... on each accepted
//   line-6 report. Without the macro, line 6 always decodes to 1.

module onehot_line_encoder #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [6:0]       line_in,
  input  logic             err_clr,
  output logic [2:0]       code_out,
  output logic             valid,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE);
  localparam logic [3:0] REL_LAST   = 4'(DEBOUNCE - 1);
  // Counter value that lights each line, indexed by line number.
  localparam logic [2:0] LINE_CODE [0:6] = '{3'd7, 3'd6, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

  state_t           state_reg;
  logic [6:0]       s1_reg;
  logic [6:0]       s2_reg;
  logic [6:0]       snap_reg;
  logic [3:0]       cnt_reg;     // settle count in SETTLE, release count in HOLD
  logic [2:0]       code_reg;
  logic             valid_reg;
  logic             err_reg;
  logic [CNT_W-1:0] evt_cnt_reg;
`ifdef ONEHOT_ENC_LINE6_ALT_EN
  logic             line6_alt_reg;
`endif

  // Encoder: each line contributes its code only when set. For a single-hot
  // snapshot, the OR of all contributions is exactly that line's code.
  logic [2:0] enc_term [0:6];
  logic [2:0] enc_base;
  logic [2:0] enc_code;
  logic       single_hot;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_enc
      assign enc_term[gi] = snap_reg[gi] ? LINE_CODE[gi] : 3'd0;
    end
  endgenerate

  always_comb begin
    enc_base = 3'd0;
    for (int i = 0; i < 7; i++) begin
      enc_base = enc_base | enc_term[i];
    end
  end

`ifdef ONEHOT_ENC_LINE6_ALT_EN
  assign enc_code = (snap_reg[6] && line6_alt_reg) ? 3'd5 : enc_base;
`else
  assign enc_code = enc_base;
`endif

  assign single_hot = (snap_reg != 7'd0) && ((snap_reg & (snap_reg - 7'd1)) == 7'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      s1_reg        <= 7'd0;
      s2_reg        <= 7'd0;
      snap_reg      <= 7'd0;
      cnt_reg       <= 4'd0;
      code_reg      <= 3'd0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      evt_cnt_reg   <= '0;
`ifdef ONEHOT_ENC_LINE6_ALT_EN
      line6_alt_reg <= 1'b0;
`endif
    end else if (!ena) begin
      // The strobe must not reappear when the enable returns.
      valid_reg <= 1'b0;
    end else begin
      s1_reg    <= line_in;
      s2_reg    <= s1_reg;
      valid_reg <= 1'b0;

      // A multi-hot report later in this block overrides the clear.
      if (err_clr) begin
        err_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (s2_reg != 7'd0) begin
            snap_reg  <= s2_reg;
            cnt_reg   <= 4'd1;
            state_reg <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (s2_reg == 7'd0) begin
            state_reg <= ST_IDLE;
          end else if (s2_reg != snap_reg) begin
            snap_reg <= s2_reg;
            cnt_reg  <= 4'd1;
          end else if (cnt_reg == DB_LAST) begin
            // Report outputs are registered on entry to REPORT, so they appear
            // DEBOUNCE+3 edges after a stable input.
            state_reg <= ST_REPORT;
            if (single_hot) begin
              code_reg    <= enc_code;
              valid_reg   <= 1'b1;
              evt_cnt_reg <= evt_cnt_reg + 1'b1;
`ifdef ONEHOT_ENC_LINE6_ALT_EN
              if (snap_reg[6]) begin
                line6_alt_reg <= ~line6_alt_reg;
              end
`endif
            end else begin
              err_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end

        ST_REPORT: begin
          cnt_reg   <= 4'd0;
          state_reg <= ST_HOLD;
        end

        ST_HOLD: begin
          // Wait for DEBOUNCE consecutive all-zero samples. Any activity
          // restarts the wait, so a pattern change is never reported.
          if (s2_reg != 7'd0) begin
            cnt_reg <= 4'd0;
          end else if (cnt_reg == REL_LAST) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign code_out = code_reg;
  assign valid    = valid_reg & ena;
  assign err      = err_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign evt_cnt  = evt_cnt_reg;

endmodule

// File: tb/tb_onehot_line_encoder.sv
module tb_onehot_line_encoder;

  localparam int DB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [6:0]    line_in = 7'd0;
  logic          err_clr = 1'b0;
  logic [2:0]    code_out;
  logic          valid;
  logic          err;
  logic          busy;
  logic [CW-1:0] evt_cnt;

  onehot_line_encoder #(.DEBOUNCE(DB), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .line_in  (line_in),
    .err_clr  (err_clr),
    .code_out (code_out),
    .valid    (valid),
    .err      (err),
    .busy     (busy),
    .evt_cnt  (evt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks how long the synchronised bus has shown the same
  // nonzero pattern (run) while waiting for a pattern, and how long it has been
  // all zero (zero_run) while waiting for release after a report.
  int        line_code [7] = '{7, 6, 2, 3, 4, 0, 1};
  logic [6:0] m_s1, m_s2, m_snap;
  int        m_run, m_zero, m_code, m_evt;
  bit        m_armed, m_skip, m_valid, m_err, m_alt;

  task automatic model_edge();
    logic [6:0] v;
    bit set_err;
    int idx;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_snap = 0; m_run = 0; m_zero = 0;
      m_code = 0; m_evt = 0; m_armed = 1; m_skip = 0;
      m_valid = 0; m_err = 0; m_alt = 0;
    end else if (!ena) begin
      m_valid = 0;
    end else begin
      v = m_s2;
      m_valid = 0;
      set_err = 0;
      if (m_armed) begin
        if (v == 0) m_run = 0;
        else if (m_run > 0 && v == m_snap) m_run++;
        else begin
          m_snap = v;
          m_run = 1;
        end
        if (m_run == DB + 1) begin
          if ($countones(m_snap) == 1) begin
            idx = 0;
            for (int i = 0; i < 7; i++) if (m_snap[i]) idx = i;
            m_code = line_code[idx];
`ifdef ONEHOT_ENC_LINE6_ALT_EN
            if (idx == 6) begin
              m_code = m_alt ? 5 : 1;
              m_alt = !m_alt;
            end
`endif
            m_valid = 1;
            m_evt = (m_evt + 1) % (1 << CW);
          end else begin
            m_err = 1;
            set_err = 1;
          end
          m_armed = 0;
          m_skip = 1;
          m_run = 0;
        end
      end else if (m_skip) begin
        m_skip = 0;
        m_zero = 0;
      end else begin
        if (v == 0) m_zero++;
        else m_zero = 0;
        if (m_zero == DB) m_armed = 1;
      end
      if (err_clr && !set_err) m_err = 0;
      m_s2 = m_s1;
      m_s1 = line_in;
    end
  endtask

  int vcount = 0;
  int last_code = 0;

  // One clock: apply inputs, advance the model at the edge, compare 1ns later.
  task automatic step(input logic [6:0] l, input logic e, input logic c, input logic r);
    line_in = l;
    ena = e;
    err_clr = c;
    rst_n = r;
    @(posedge clk);
    model_edge();
    #1;
    check("valid", 32'(valid), 32'(m_valid && ena));
    check("code_out", 32'(code_out), 32'(m_code));
    check("err", 32'(err), 32'(m_err));
    check("evt_cnt", 32'(evt_cnt), 32'(m_evt));
    check("busy", 32'(busy), 32'(!m_armed || m_run > 0));
    if (valid === 1'b1) begin
      vcount++;
      last_code = code_out;
    end
  endtask

  task automatic hold(input logic [6:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(7'd0, 1'b1, 1'b0, 1'b0);
    step(7'd0, 1'b1, 1'b0, 1'b0);
  endtask

  int first;
  int v0;
  int codes [3];
  logic [6:0] pat;
  int len;

  initial begin
    do_reset();
    check("reset_code", 32'(code_out), 0);
    check("reset_busy", 32'(busy), 0);

    // Latency: stable input before E1 gives valid right after E(3+DEBOUNCE).
    first = 0;
    for (int k = 1; k <= 16; k++) begin
      step(7'b0001000, 1'b1, 1'b0, 1'b1);
      if (valid === 1'b1 && first == 0) first = k;
    end
    check("latency", first, DB + 3);
    check("lat_code", 32'(code_out), 3);
    check("lat_evt", 32'(evt_cnt), 1);
    hold(7'd0, 10);

    // Two patterns with release: codes 0 then 7.
    v0 = vcount;
    hold(7'b0100000, 12);
    hold(7'd0, 10);
    check("seq_code0", last_code, 0);
    hold(7'b0000001, 12);
    hold(7'd0, 10);
    check("seq_code7", last_code, 7);
    check("seq_strobes", vcount - v0, 2);

    // Glitching bus never settles, then steady line 2 is reported once.
    v0 = vcount;
    for (int k = 0; k < 10; k++) hold((k % 2) ? 7'b0001000 : 7'b0000100, 2);
    check("glitch_quiet", vcount - v0, 0);
    hold(7'b0000100, 12);
    check("glitch_once", vcount - v0, 1);
    check("glitch_code", last_code, 2);
    hold(7'd0, 10);

    // Multi-hot error, clear, and clear coinciding with a new error.
    v0 = vcount;
    hold(7'b0010010, 12);
    check("mh_err", 32'(err), 1);
    check("mh_novalid", vcount - v0, 0);
    check("mh_code", 32'(code_out), 2);
    hold(7'd0, 10);
    step(7'd0, 1'b1, 1'b1, 1'b1);
    check("err_clr", 32'(err), 0);
    hold(7'd0, 4);
    for (int k = 1; k <= 12; k++) step(7'b1100000, 1'b1, (k == DB + 3), 1'b1);
    check("err_set_wins", 32'(err), 1);
    hold(7'd0, 10);

    // Line 6 three times from reset.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      v0 = vcount;
      hold(7'b1000000, 10);
      check("l6_strobe", vcount - v0, 1);
      codes[r] = last_code;
      hold(7'd0, 10);
    end
    check("l6_first", codes[0], 1);
`ifdef ONEHOT_ENC_LINE6_ALT_EN
    check("l6_second", codes[1], 5);
`else
    check("l6_second", codes[1], 1);
`endif
    check("l6_third", codes[2], 1);

    // Reset during SETTLE discards the capture.
    v0 = vcount;
    hold(7'b0010000, 4);
    step(7'd0, 1'b1, 1'b0, 1'b0);
    step(7'd0, 1'b1, 1'b0, 1'b0);
    hold(7'd0, 10);
    check("rst_novalid", vcount - v0, 0);
    check("rst_evt", 32'(evt_cnt), 0);
    check("rst_code", 32'(code_out), 0);

    // ena low for 5 cycles mid-SETTLE delays the report by 5.
    first = 0;
    for (int k = 1; k <= 24; k++) begin
      step(7'b0000010, (k < 5 || k > 9), 1'b0, 1'b1);
      if (valid === 1'b1 && first == 0) first = k;
    end
    check("ena_delay", first, DB + 3 + 5);
    hold(7'd0, 10);

    // Counter wrap after 2^CW events from reset.
    do_reset();
    for (int k = 0; k < (1 << CW); k++) begin
      hold(7'b0000001 << (k % 7), 8);
      hold(7'd0, 8);
    end
    check("evt_wrap", 32'(evt_cnt), 0);

    // Randomised phases against the model.
    for (int p = 0; p < 80; p++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: pat = 7'b0000001 << $urandom_range(0, 6);
        4:          pat = (7'b0000001 << $urandom_range(0, 6)) | (7'b0000001 << $urandom_range(0, 6));
        default:    pat = 7'd0;
      endcase
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++)
        step(pat, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 99) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
